// File: rtl/pic_pkg.sv
// Shared constants, OCW2 command codes and FSM encoding for the 8259A sequencing core.
package pic_pkg;

  localparam int unsigned IR_COUNT = 8;
  localparam int unsigned VEC_W    = 8;
  localparam int unsigned LVL_W    = 3;

  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] EOI_SP       = 3'b011;
  localparam logic [2:0] ROT_NS       = 3'b101;
  localparam logic [2:0] ROT_SP       = 3'b111;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StAck1 = 3'd2,
    StAck2 = 3'd3,
    StDone = 3'd4
  } pic_state_e;

  // Priority rank of a level: 0 is highest, i.e. the level just above the pointer.
  function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] ptr);
    return level - ptr - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating find-first: returns the highest-priority set bit given the
// lowest-priority pointer.
module pic_priority_resolver (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic       found_o,
  output logic [2:0] level_o
);

  logic [7:0] rot;
  logic [2:0] idx;

  always_comb begin
    rot = '0;
    idx = '0;
    // rot[0] holds the highest-priority line
    for (int i = 0; i < 8; i++) begin
      rot[i] = req_i[ptr_i + 3'd1 + 3'(i)];
    end
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        idx = 3'(i);
      end
    end
    found_o = |req_i;
    level_o = ptr_i + 3'd1 + idx;
  end

endmodule

// File: rtl/pic_priority_sequencer.sv
// 8259A interrupt sequencing core: IRR/ISR tracking, fully nested priority resolution,
// two-pulse INTA handshake and OCW2 EOI/rotation handling.
module pic_priority_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_valid,
  input  logic [2:0] eoi_cmd,
  input  logic [2:0] eoi_level,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  pic_state_e state_q, state_d;
  logic [7:0] ir_q;
  logic       inta_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] ptr_q, ptr_d;
  logic       rot_aeoi_q, rot_aeoi_d;
  logic [2:0] w_q, w_d;
  logic       spur_q, spur_d;
  logic [7:0] vector_q, vector_d;
  logic       vv_q, vv_d;
  logic       int_q, int_d;

  logic [7:0] req_masked;
  logic       win_found, top_found;
  logic [2:0] win_lvl, top_lvl;
  logic       inta_fall, pending;
  logic [7:0] ack_set, aeoi_clr, eoi_clr;
  logic       ack_ptr_we, eoi_ptr_we;
  logic [2:0] eoi_ptr;

  assign req_masked = irr_q & ~imr;
  assign inta_fall  = inta_q & ~inta_n;

  pic_priority_resolver u_win (
    .req_i   (req_masked),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .level_o (win_lvl)
  );

  pic_priority_resolver u_top (
    .req_i   (isr_q),
    .ptr_i   (ptr_q),
    .found_o (top_found),
    .level_o (top_lvl)
  );

  // Fully nested: an in-service level of equal or higher priority blocks the request.
  assign pending = win_found &&
                   (!top_found || (prio_rank(win_lvl, ptr_q) < prio_rank(top_lvl, ptr_q)));

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    spur_d     = spur_q;
    vector_d   = vector_q;
    vv_d       = vv_q;
    ack_set    = '0;
    aeoi_clr   = '0;
    ack_ptr_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) state_d = StReq;
      end
      StReq: begin
        if (inta_fall) begin
          state_d = StAck1;
          if (win_found) begin
            w_d     = win_lvl;
            spur_d  = 1'b0;
            ack_set = 8'h01 << win_lvl;
          end else begin
            w_d    = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_n) state_d = StAck2;
      end
      StAck2: begin
        if (!vv_q && inta_fall) begin
          vv_d     = 1'b1;
          vector_d = {vector_base, w_q};
        end else if (vv_q && inta_n) begin
          vv_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (aeoi && !spur_q) begin
          aeoi_clr   = 8'h01 << w_q;
          ack_ptr_we = rot_aeoi_q;
        end
      end
      default: state_d = StIdle;
    endcase
    int_d = (state_d == StReq);
  end

  always_comb begin
    eoi_clr    = '0;
    eoi_ptr_we = 1'b0;
    eoi_ptr    = eoi_level;
    rot_aeoi_d = rot_aeoi_q;
    if (eoi_valid) begin
      case (eoi_cmd)
        EOI_NS: begin
          if (top_found) eoi_clr = 8'h01 << top_lvl;
        end
        ROT_NS: begin
          if (top_found) begin
            eoi_clr    = 8'h01 << top_lvl;
            eoi_ptr_we = 1'b1;
            eoi_ptr    = top_lvl;
          end
        end
        EOI_SP: eoi_clr = 8'h01 << eoi_level;
        ROT_SP: begin
          eoi_clr    = 8'h01 << eoi_level;
          eoi_ptr_we = 1'b1;
        end
        SET_PRI:      eoi_ptr_we = 1'b1;
        ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (ltim) begin
      irr_d = ir;
    end else begin
      irr_d = (irr_q | (ir & ~ir_q)) & ir;
    end
    irr_d = irr_d & ~ack_set;
    // Acknowledge set takes precedence over a simultaneous clear of the same bit.
    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | ack_set;
    if (eoi_ptr_we) begin
      ptr_d = eoi_ptr;
    end else if (ack_ptr_we) begin
      ptr_d = w_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      inta_q     <= 1'b1;
      irr_q      <= '0;
      isr_q      <= '0;
      ptr_q      <= 3'd7;
      rot_aeoi_q <= 1'b0;
      w_q        <= '0;
      spur_q     <= 1'b0;
      vector_q   <= '0;
      vv_q       <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir;
      inta_q     <= inta_n;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      ptr_q      <= ptr_d;
      rot_aeoi_q <= rot_aeoi_d;
      w_q        <= w_d;
      spur_q     <= spur_d;
      vector_q   <= vector_d;
      vv_q       <= vv_d;
      int_q      <= int_d;
    end
  end

  assign int_out      = int_q;
  assign vector       = vector_q;
  assign vector_valid = vv_q;
  assign irr          = irr_q;
  assign isr          = isr_q;

endmodule

// File: tb/tb_pic_priority_sequencer.sv
// Directed self-checking bench for pic_priority_sequencer.
module tb_pic_priority_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       ltim;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       eoi_valid;
  logic [2:0] eoi_cmd;
  logic [2:0] eoi_level;
  logic       inta_n;
  logic       int_out;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pic_priority_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ir           (ir),
    .ltim         (ltim),
    .imr          (imr),
    .vector_base  (vector_base),
    .aeoi         (aeoi),
    .eoi_valid    (eoi_valid),
    .eoi_cmd      (eoi_cmd),
    .eoi_level    (eoi_level),
    .inta_n       (inta_n),
    .int_out      (int_out),
    .vector       (vector),
    .vector_valid (vector_valid),
    .irr          (irr),
    .isr          (isr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_eoi(input logic [2:0] cmd, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_cmd   = cmd;
    eoi_level = lvl;
    tick();
    eoi_valid = 1'b0;
  endtask

  // Full two-pulse handshake; ends with the FSM back in idle.
  task automatic handshake(input string tag, input logic [7:0] exp_isr, input logic [7:0] exp_vec);
    inta_n = 1'b0;
    tick();
    check_eq({tag, "_isr"}, 32'(isr), 32'(exp_isr));
    check_eq({tag, "_int_drop"}, 32'(int_out), 32'd0);
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check_eq({tag, "_vv_rise"}, 32'(vector_valid), 32'd1);
    check_eq({tag, "_vec"}, 32'(vector), 32'(exp_vec));
    tick();
    inta_n = 1'b1;
    tick();
    check_eq({tag, "_vv_fall"}, 32'(vector_valid), 32'd0);
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    ir          = '0;
    ltim        = 1'b0;
    imr         = '0;
    vector_base = 5'h08;
    aeoi        = 1'b0;
    eoi_valid   = 1'b0;
    eoi_cmd     = '0;
    eoi_level   = '0;
    inta_n      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_int", 32'(int_out), 32'd0);
    check_eq("rst_vec", 32'(vector), 32'd0);
    check_eq("rst_vv", 32'(vector_valid), 32'd0);
    check_eq("rst_irr", 32'(irr), 32'd0);
    check_eq("rst_isr", 32'(isr), 32'd0);
    check_eq("rst_ptr", 32'(dut.ptr_q), 32'd7);

    // Edge mode, single request on IR3
    ir = 8'h08;
    tick();
    check_eq("t1_irr", 32'(irr), 32'h08);
    check_eq("t1_int_early", 32'(int_out), 32'd0);
    tick();
    check_eq("t1_int", 32'(int_out), 32'd1);
    handshake("t1", 8'h08, 8'h43);
    check_eq("t1_irr_after", 32'(irr), 32'h00);

    // Nesting: IR5 blocked by in-service IR3, IR1 preempts
    ir = 8'h28;
    tick();
    check_eq("t2_irr5", 32'(irr), 32'h20);
    tick();
    tick();
    check_eq("t2_blocked", 32'(int_out), 32'd0);
    ir = 8'h2a;
    tick();
    tick();
    check_eq("t2_int", 32'(int_out), 32'd1);
    handshake("t2", 8'h0a, 8'h41);
    check_eq("t2_irr", 32'(irr), 32'h20);
    send_eoi(3'b001, 3'd0);
    check_eq("t2_eoi_ns", 32'(isr), 32'h08);
    send_eoi(3'b011, 3'd3);
    check_eq("t2_eoi_sp", 32'(isr), 32'h00);
    tick();
    check_eq("t2_int5", 32'(int_out), 32'd1);
    handshake("t2b", 8'h20, 8'h45);
    ir = 8'h00;
    send_eoi(3'b011, 3'd5);
    check_eq("t2_isr_clr", 32'(isr), 32'h00);

    // Spurious: level request withdrawn before first INTA
    ltim = 1'b1;
    ir   = 8'h04;
    tick();
    check_eq("t3_irr", 32'(irr), 32'h04);
    tick();
    check_eq("t3_int", 32'(int_out), 32'd1);
    ir = 8'h00;
    tick();
    handshake("t3", 8'h00, 8'h47);
    check_eq("t3_irr_after", 32'(irr), 32'h00);
    ltim = 1'b0;
    tick();

    // Rotation on non-specific EOI, then IR5 beats IR4
    ir = 8'h10;
    tick();
    tick();
    handshake("t4", 8'h10, 8'h44);
    ir = 8'h00;
    send_eoi(3'b101, 3'd0);
    check_eq("t4_isr", 32'(isr), 32'h00);
    check_eq("t4_ptr", 32'(dut.ptr_q), 32'd4);
    ir = 8'h30;
    tick();
    tick();
    check_eq("t4_int", 32'(int_out), 32'd1);
    handshake("t4b", 8'h20, 8'h45);
    ir = 8'h00;
    send_eoi(3'b001, 3'd0);
    check_eq("t4_isr_clr", 32'(isr), 32'h00);
    send_eoi(3'b101, 3'd0);
    check_eq("t4_ns_empty_ptr", 32'(dut.ptr_q), 32'd4);
    send_eoi(3'b110, 3'd2);
    check_eq("t4_set_pri", 32'(dut.ptr_q), 32'd2);

    // AEOI with rotation on IR6
    aeoi = 1'b1;
    send_eoi(3'b100, 3'd0);
    ir = 8'h40;
    tick();
    tick();
    check_eq("t5_int", 32'(int_out), 32'd1);
    handshake("t5", 8'h40, 8'h46);
    check_eq("t5_isr", 32'(isr), 32'h00);
    check_eq("t5_ptr", 32'(dut.ptr_q), 32'd6);
    ir   = 8'h00;
    aeoi = 1'b0;
    tick();

    // Reset while the vector is being driven
    ir = 8'h01;
    tick();
    tick();
    check_eq("t6_int", 32'(int_out), 32'd1);
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check_eq("t6_vv", 32'(vector_valid), 32'd1);
    check_eq("t6_vec", 32'(vector), 32'h40);
    reset  = 1'b1;
    inta_n = 1'b1;
    ir     = 8'h00;
    tick();
    check_eq("t6_int_rst", 32'(int_out), 32'd0);
    check_eq("t6_vec_rst", 32'(vector), 32'd0);
    check_eq("t6_vv_rst", 32'(vector_valid), 32'd0);
    check_eq("t6_irr_rst", 32'(irr), 32'd0);
    check_eq("t6_isr_rst", 32'(isr), 32'd0);
    check_eq("t6_ptr_rst", 32'(dut.ptr_q), 32'd7);
    check_eq("t6_fsm_rst", 32'(dut.state_q), 32'(pic_pkg::StIdle));
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_priority_sequencer.md
# pic_priority_sequencer

Interrupt sequencing core of the 8259A PIC, sitting behind the read/write logic that decodes ICW/OCW writes. It latches IR requests into IRR, resolves priority against IMR and the in-service set, and raises INT. It runs the two-pulse INTA handshake, presents the vector byte, and executes EOI and rotation commands delivered from OCW2. IRR and ISR are exported for the read-back mux.

## Interface
- IR_COUNT, 8: number of request lines. Fixed at 8; other values are unsupported.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ir  in  8  request lines, already synchronized to clk.
- ltim  in  1  trigger mode (ICW1 D3): 1 = level, 0 = edge.
- imr  in  8  mask (OCW1); 1 masks the line.
- vector_base  in  5  T7..T3 from ICW2.
- aeoi  in  1  auto-EOI enable (ICW4 D1).
- eoi_valid  in  1  one-cycle strobe; OCW2 command present this cycle.
- eoi_cmd  in  3  OCW2 {R, SL, EOI}.
- eoi_level  in  3  OCW2 L2..L0.
- inta_n  in  1  CPU acknowledge, active-low, synchronized.
- int_out  out  1  INT to the CPU.
- vector  out  8  vector byte.
- vector_valid  out  1  vector must be driven onto D.
- irr  out  8  interrupt request register.
- isr  out  8  in-service register.

## Operation
- Priority order: highest priority is (ptr+1) mod 8, descending cyclically from there. ptr is the 3-bit lowest-priority pointer, reset value 7 (IR0 highest).
- IRR, edge mode: bit sets on a 0→1 transition of ir (registered ir_q). It clears when ir is low or when the line is acknowledged.
- IRR, level mode: bit follows ir, except that it clears on acknowledge.
- Winner: the highest-priority bit of irr & ~imr.
- Pending: a winner exists and its priority is strictly above the highest-priority set bit of isr (fully nested). An equal or lower in-service level blocks the request.
- FSM states:
  - IDLE: on pending, go to REQ.
  - REQ: int_out=1. On an INTA falling edge, go to ACK1. At that edge, latch the winner:
    - If a winner exists: set isr[w] and clear irr[w].
    - If no winner exists (request withdrawn): w=7, spurious; no ISR/IRR change.
  - ACK1: int_out=0. Wait for inta_n high, then go to ACK2.
  - ACK2: on the next INTA falling edge, vector={vector_base,w}, vector_valid=1 while inta_n stays low. When inta_n rises, go to DONE.
  - DONE: vector_valid=0. If aeoi is set and the cycle was not spurious, clear isr[w]; if rotate_aeoi is also set, ptr=w. Then go to IDLE.
- eoi_cmd decoding (processed only on eoi_valid; "top" = highest-priority set isr bit):
  - 001: clear top.
  - 011: clear isr[eoi_level].
  - 101: clear top; ptr=top.
  - 111: clear isr[eoi_level]; ptr=eoi_level.
  - 110: ptr=eoi_level.
  - 100: rotate_aeoi=1.
  - 000: rotate_aeoi=0.
  - 010: no-op.
  - Non-specific EOI with isr==0: no change.
- Simultaneous events:
  - EOI clear and acknowledge set in the same cycle: both apply.
  - If they target the same bit, the set wins.
  - If both write ptr, the EOI write wins.

## Timing
- Reset values: int_out=0, vector=0, vector_valid=0, irr=0, isr=0, ptr=7, rotate_aeoi=0, FSM=IDLE, ir_q=0, inta_q=1.
- Reset asserted mid-handshake returns everything to these values on the next edge; the in-flight acknowledge is dropped.
- ir edge sampled at edge N → irr bit at N+1 → int_out at N+2 (all outputs registered).
- INTA falling edge is detected as inta_q & ~inta_n.
- First acknowledge: ISR/IRR update and int_out deassert take effect one cycle after the detect.
- Second acknowledge: vector_valid rises one cycle after the detect and falls one cycle after inta_n rises.
- A new pending request during ACK1/ACK2/DONE is held until IDLE. Re-assertion of int_out takes at least 1 cycle from IDLE.
- Priority resolution is combinational within one cycle; there is no multi-cycle search.

## Structure
- pic_pkg holds:
  - EOI command localparams (EOI_NS=3'b001, EOI_SP=3'b011, ROT_NS=3'b101, ROT_SP=3'b111, SET_PRI=3'b110, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000).
  - FSM state encoding {IDLE, REQ, ACK1, ACK2, DONE}.
  - IR_COUNT and vector-width constants.
- Sub-module pic_priority_resolver (combinational): inputs 8-bit mask and ptr; outputs found flag and 3-bit level. It rotates, performs a find-first, and un-rotates.
- Instantiate it twice: once for the request winner and once for the ISR top.

## Test plan
- Edge mode, imr=0, vector_base=5'h08: pulse ir[3]. int_out must rise 2 cycles later. Two INTA pulses must give vector=8'h43, isr=8'h08, irr[3]=0.
- Nesting: with isr[3] set, raise ir[5] (no int_out) and ir[1]. int_out must rise; acknowledge must give vector level 1 and isr=8'h0A. eoi_cmd=001 must clear bit 1.
- Spurious: raise ir[2] in level mode and drop it before the first INTA. Vector must be {base,3'd7}, with isr and irr unchanged.
- Rotation: isr[4] set, eoi_cmd=101 must give isr=0 and ptr=4. With ir[4] and ir[5] both requesting, IR5 must win.
- AEOI with rotate_aeoi=1 (eoi_cmd=100 first): acknowledge IR6. isr must return to 0 after the second INTA, and ptr must be 6.
- Reset asserted in ACK2 with vector_valid=1: next cycle all outputs must be zero, ptr=7, FSM=IDLE.
